// File: rtl/dc_offset_remover_pkg.sv
// Shared types and helpers for the zero-crossing frequency detector signal chain.
// Imported by dc_offset_remover and by the blocks on the freq_detector side.
package dc_offset_remover_pkg;

   typedef enum logic {ACQUIRE, TRACK} dcr_state_t;

   // Clamp a signed value to the range of a signed word of the given width.
   function automatic int sat_narrow(input int value, input int unsigned width);
      int hi;
      int lo;
      hi = (1 <<< (width - 1)) - 1;
      lo = -(1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      return value;
   endfunction

endpackage

// File: rtl/dc_offset_remover_if.sv
// Sample and statistics bundle between the ADC front end and the DC offset remover.
// The producer owns data_in; the remover drives everything else.
interface dc_offset_remover_if #(
   parameter int DATA_WIDTH = 12
);
   logic        [DATA_WIDTH-1:0] data_in;
   logic signed [DATA_WIDTH-1:0] data_out;
   logic        [DATA_WIDTH-1:0] offset;
   logic        [DATA_WIDTH-1:0] amplitude;
   logic                         offset_valid;
   logic                         signal_present;
   logic                         win_done;

   modport master (
      output data_in,
      input  data_out, offset, amplitude, offset_valid, signal_present, win_done
   );

   modport slave (
      input  data_in,
      output data_out, offset, amplitude, offset_valid, signal_present, win_done
   );
endinterface

// File: rtl/dc_offset_remover_win_extrema.sv
// Per-window running max/min tracker. max_f/min_f already include the current sample,
// so the window-end edge can latch statistics without an extra cycle.
module win_extrema
   import dc_offset_remover_pkg::*;
#(
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] sample,
   output logic [DATA_WIDTH-1:0] max_f,
   output logic [DATA_WIDTH-1:0] min_f
);

   logic [DATA_WIDTH-1:0] max_r;
   logic [DATA_WIDTH-1:0] min_r;

   always_comb begin
      max_f = sample;
      min_f = sample;
      if (!load) begin
         max_f = (sample > max_r) ? sample : max_r;
         min_f = (sample < min_r) ? sample : min_r;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_r <= '0;
         min_r <= '0;
      end else begin
         max_r <= max_f;
         min_r <= min_f;
      end
   end

endmodule

// File: rtl/dc_offset_remover.sv
// Removes the DC offset from raw unsigned ADC samples using the midpoint of each window's
// min/max, and reports half peak-to-peak amplitude plus a signal-present flag.
module dc_offset_remover
   import dc_offset_remover_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int WIN_LOG2    = 10,
   parameter int MIN_AMP     = 16,
   parameter int OFFSET_INIT = 2048
) (
   input  logic             adc_clk,
   input  logic             rst_n,
   dc_offset_remover_if.slave bus
);

   localparam logic [DATA_WIDTH-1:0] OFFSET_INIT_W = DATA_WIDTH'(OFFSET_INIT);

   dcr_state_t                   state;
   logic [WIN_LOG2-1:0]          win_cnt;
   logic                         win_start;
   logic                         win_end;
   logic [DATA_WIDTH-1:0]        max_f;
   logic [DATA_WIDTH-1:0]        min_f;
   logic [DATA_WIDTH:0]          mid_sum;
   logic [DATA_WIDTH-1:0]        span;
   logic [DATA_WIDTH-1:0]        offset_next;
   logic [DATA_WIDTH-1:0]        amp_next;

   logic [DATA_WIDTH-1:0]        offset_r;
   logic [DATA_WIDTH-1:0]        amplitude_r;
   logic                         offset_valid_r;
   logic                         signal_present_r;
   logic                         win_done_r;
   logic [DATA_WIDTH-1:0]        d1;
   logic signed [DATA_WIDTH:0]   diff;
   logic signed [DATA_WIDTH-1:0] data_out_r;

   assign win_start = (win_cnt == '0);
   assign win_end   = (win_cnt == '1);

   win_extrema #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_extrema (
      .clk    (adc_clk),
      .rst_n  (rst_n),
      .load   (win_start),
      .sample (bus.data_in),
      .max_f  (max_f),
      .min_f  (min_f)
   );

   // One extra bit on the sum so full-scale max+min cannot overflow before halving.
   always_comb begin
      mid_sum     = {1'b0, max_f} + {1'b0, min_f};
      offset_next = mid_sum[DATA_WIDTH:1];
      span        = max_f - min_f;
      amp_next    = span >> 1;
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n)
         win_cnt <= '0;
      else
         win_cnt <= win_cnt + 1'b1;
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ACQUIRE;
         offset_r         <= OFFSET_INIT_W;
         amplitude_r      <= '0;
         offset_valid_r   <= 1'b0;
         signal_present_r <= 1'b0;
         win_done_r       <= 1'b0;
      end else begin
         win_done_r <= win_end;
         if (win_end) begin
            offset_r         <= offset_next;
            amplitude_r      <= amp_next;
            signal_present_r <= (int'(amp_next) >= MIN_AMP);
            offset_valid_r   <= 1'b1;
         end
         case (state)
            ACQUIRE: if (win_end) state <= TRACK;
            TRACK:   state <= TRACK;
         endcase
      end
   end

   // d1 pairs with the offset register as it stands after the same edge, so the
   // window's last sample is the first one corrected by that window's new offset.
   always_comb diff = $signed({1'b0, d1}) - $signed({1'b0, offset_r});

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         d1         <= '0;
         data_out_r <= '0;
      end else begin
         d1         <= bus.data_in;
         data_out_r <= DATA_WIDTH'(sat_narrow(int'(diff), DATA_WIDTH));
      end
   end

   assign bus.data_out       = data_out_r;
   assign bus.offset         = offset_r;
   assign bus.amplitude      = amplitude_r;
   assign bus.offset_valid   = offset_valid_r;
   assign bus.signal_present = signal_present_r;
   assign bus.win_done       = win_done_r;

endmodule
